// File: rtl/event_out_fifo.sv
// event_out_fifo: buffers granted arbiter events for the readout link.
// Optional EVT_TIMESTAMP_EN prepends a TS_W-bit cycle timestamp to each word.
module event_out_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16,
`ifdef EVT_TIMESTAMP_EN
    localparam int OW   = TS_W + WIDTH,
`else
    localparam int OW   = WIDTH + (TS_W * 0),
`endif
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic          evt_valid_i,
    input  logic [WIDTH-1:0] evt_data_i,
    input  logic          out_ready_i,
    output logic          out_valid_o,
    output logic [OW-1:0] out_data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          overflow_o
);

    logic [OW-1:0] mem_q [DEPTH];
    logic [OW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          wr_req, push, pop;
    logic [OW-1:0] wr_word;

    assign level_o     = level_q;
    assign empty_o     = (level_q == '0);
    assign full_o      = (level_q == LW'(DEPTH));
    assign out_valid_o = ~empty_o;
    assign out_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign overflow_o  = overflow_q;

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // Free-running timestamp, frozen while capture is disabled
    always_comb begin
        ts_d    = enable_i ? ts_q + TS_W'(1) : ts_q;
        wr_word = {ts_q, evt_data_i};
    end

    // Timestamp register
    always_ff @(posedge clk_i) begin
        if (reset_i) ts_q <= '0;
        else         ts_q <= ts_d;
    end
`else
    assign wr_word = evt_data_i;
`endif

    // Push/pop decisions, storage write, pointer and level update
    always_comb begin
        wr_req     = evt_valid_i & enable_i;
        push       = wr_req & ~full_o;
        pop        = out_valid_o & out_ready_i;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (wr_req & full_o);
        if (push) begin
            mem_d[wr_ptr_q] = wr_word;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers; reset clears contents so out_data_o reads zero
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_event_out_fifo.sv
// tb_event_out_fifo: directed stimulus with a queue-based reference model.
// Builds with or without EVT_TIMESTAMP_EN.
module tb_event_out_fifo;

    localparam int WIDTH = 12;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
`ifdef EVT_TIMESTAMP_EN
    localparam int OW = TS_W + WIDTH;
`else
    localparam int OW = WIDTH;
`endif
    localparam int LW = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic             rdy;
    logic             ov;
    logic [OW-1:0]    od;
    logic [LW-1:0]    lvl;
    logic             full, empty, ovf;

    int errors = 0;
    int checks = 0;

    event_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en),
        .evt_valid_i(ev), .evt_data_i(ed), .out_ready_i(rdy),
        .out_valid_o(ov), .out_data_o(od), .level_o(lvl),
        .full_o(full), .empty_o(empty), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [OW-1:0]   mq[$];
    bit              m_ovf = 0;
    logic [TS_W-1:0] m_ts = '0;
    bit              started = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf   = 0;
            m_ts    = '0;
            started = 1;
        end else begin
            bit is_full, do_push, do_pop;
            logic [OW-1:0] w;
            is_full = (mq.size() == DEPTH);
            do_push = ev && en && !is_full;
            do_pop  = (mq.size() > 0) && rdy;
            if (ev && en && is_full) m_ovf = 1;
`ifdef EVT_TIMESTAMP_EN
            w = {m_ts, ed};
`else
            w = ed;
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(w);
            if (en) m_ts = m_ts + 1'b1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            logic [OW-1:0] eh;
            eh = (mq.size() != 0) ? mq[0] : '0;
            check("m_valid", 64'(ov), 64'(mq.size() != 0));
            check("m_data", 64'(od), 64'(eh));
            check("m_level", 64'(lvl), 64'(mq.size()));
            check("m_full", 64'(full), 64'(mq.size() == DEPTH));
            check("m_empty", 64'(empty), 64'(mq.size() == 0));
            check("m_ovf", 64'(ovf), 64'(m_ovf));
        end
    end

    task automatic cyc(input bit v, input logic [WIDTH-1:0] d,
                       input bit r, input bit e);
        ev = v; ed = d; rdy = r; en = e;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, '0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ev = 1'b0; ed = '0; rdy = 1'b0;
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        rst = 1'b0;
        check("rst_level", 64'(lvl), 64'd0);
        check("rst_valid", 64'(ov), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_data", 64'(od), 64'd0);

        // Single push with fall-through
        cyc(1, 12'h0A5, 1, 1);
        check("single_valid", 64'(ov), 64'd1);
        check("single_data", 64'(od[WIDTH-1:0]), 64'h0A5);
        cyc(0, '0, 1, 1);
        check("single_level0", 64'(lvl), 64'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) cyc(1, WIDTH'(12'h100 + i), 0, 1);
        check("fill_full", 64'(full), 64'd1);
        check("fill_level", 64'(lvl), 64'd16);
        cyc(1, 12'h1FF, 0, 1);
        check("fill_ovf", 64'(ovf), 64'd1);
        check("fill_level_kept", 64'(lvl), 64'd16);
        check("fill_head", 64'(od[WIDTH-1:0]), 64'h100);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", 64'(od[WIDTH-1:0]), 64'(12'h100 + i));
            cyc(0, '0, 1, 1);
        end
        check("drain_empty", 64'(empty), 64'd1);

        // Level 3, streaming push+pop with pointer wrap
        for (int i = 0; i < 3; i++) cyc(1, WIDTH'(12'h200 + i), 0, 1);
        for (int i = 0; i < 40; i++) begin
            cyc(1, WIDTH'(12'h300 + i), 1, 1);
            check("stream_level", 64'(lvl), 64'd3);
        end
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 1);
        check("stream_drained", 64'(empty), 64'd1);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, WIDTH'(12'h400 + i), 0, 1);
        cyc(1, 12'h4FF, 1, 1);
        check("fullpp_ovf", 64'(ovf), 64'd1);
        check("fullpp_level", 64'(lvl), 64'd15);
        check("fullpp_head", 64'(od[WIDTH-1:0]), 64'h401);

        // Disabled: pushes ignored without overflow, pops still drain
        do_reset();
        cyc(1, 12'h055, 0, 0);
        check("dis_nopush", 64'(lvl), 64'd0);
        cyc(1, 12'h511, 0, 1);
        cyc(1, 12'h522, 0, 1);
        cyc(1, 12'h533, 1, 0);
        cyc(1, 12'h544, 1, 0);
        check("dis_drain", 64'(lvl), 64'd0);
        check("dis_noovf", 64'(ovf), 64'd0);

`ifdef EVT_TIMESTAMP_EN
        // Timestamps of pushes five enabled cycles apart
        begin
            logic [OW-1:0] wa, wb;
            do_reset();
            cyc(0, '0, 0, 1);
            cyc(0, '0, 0, 1);
            cyc(1, 12'h0AA, 0, 1);
            for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1);
            cyc(1, 12'h0BB, 0, 1);
            wa = od;
            cyc(0, '0, 1, 0);
            wb = od;
            check("ts_first", 64'(wa[OW-1:WIDTH]), 64'd2);
            check("ts_diff", 64'(wb[OW-1:WIDTH] - wa[OW-1:WIDTH]), 64'd5);
            cyc(0, '0, 1, 0);
        end
`endif

        // Reset with level 5, sticky overflow and no readiness
        do_reset();
        for (int i = 0; i < 17; i++) cyc(1, WIDTH'(12'h600 + i), 0, 1);
        for (int i = 0; i < 11; i++) cyc(0, '0, 1, 1);
        check("pre_rst_level", 64'(lvl), 64'd5);
        check("pre_rst_ovf", 64'(ovf), 64'd1);
        rst = 1'b1;
        cyc(0, '0, 0, 1);
        rst = 1'b0;
        check("mid_rst_level", 64'(lvl), 64'd0);
        check("mid_rst_valid", 64'(ov), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        cyc(0, '0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
